// File: rtl/dec_frame_deser.sv
// Serial-to-parallel codeword collector for the decoder front end.
// Gathers an 8/16/32-bit MSB-first bit stream into a right-aligned word with a valid strobe.
module dec_frame_deser #(
    parameter int unsigned MAX_CODEWORD_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          start,
    input  logic [1:0]                    work_mod,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic                          data_valid,
    output logic [1:0]                    mod_out,
    output logic                          frame_err
);

    localparam int unsigned SHIFT_W = 32;
    localparam int unsigned CNT_W   = 6;
    localparam logic [1:0]  MODE_BAD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RX   = 1'b1
    } state_t;

    state_t                        r_state;
    logic [CNT_W-1:0]              r_count;
    logic [SHIFT_W-1:0]            r_shift;
    logic [1:0]                    r_mode;

    state_t                        w_state_nxt;
    logic [CNT_W-1:0]              w_count_nxt;
    logic [SHIFT_W-1:0]            w_shift_nxt;
    logic [1:0]                    w_mode_nxt;
    logic [MAX_CODEWORD_WIDTH-1:0] w_data_nxt;
    logic                          w_valid_nxt;
    logic [1:0]                    w_mod_out_nxt;
    logic                          w_err_nxt;
    logic [SHIFT_W-1:0]            w_shifted;
    logic                          w_rx_bit;
    logic                          w_last;

    // Index of the final bit of a frame for a given mode.
    function automatic logic [CNT_W-1:0] last_idx(input logic [1:0] mode);
        case (mode)
            2'b00:   last_idx = CNT_W'(7);
            2'b01:   last_idx = CNT_W'(15);
            default: last_idx = CNT_W'(31);
        endcase
    endfunction

    assign w_shifted = {r_shift[SHIFT_W-2:0], bit_in};
    assign w_rx_bit  = (r_state == ST_RX) && bit_valid;
    assign w_last    = w_rx_bit && (r_count == last_idx(r_mode));

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_shift_nxt   = r_shift;
        w_mode_nxt    = r_mode;
        w_data_nxt    = data_out;
        w_valid_nxt   = 1'b0;
        w_mod_out_nxt = mod_out;
        w_err_nxt     = 1'b0;

        if (w_last) begin
            w_data_nxt    = MAX_CODEWORD_WIDTH'(w_shifted);
            w_valid_nxt   = 1'b1;
            w_mod_out_nxt = r_mode;
            w_state_nxt   = ST_IDLE;
            w_count_nxt   = '0;
            w_shift_nxt   = '0;
        end else if (w_rx_bit) begin
            w_shift_nxt = w_shifted;
            w_count_nxt = r_count + CNT_W'(1);
        end

        // A start overrides frame progress; a bit on a completing cycle belongs to the old frame.
        if (start) begin
            if ((r_state == ST_RX) && !w_last) begin
                w_err_nxt = 1'b1;
            end
            if (work_mod == MODE_BAD) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
                w_shift_nxt = '0;
            end else begin
                w_mode_nxt  = work_mod;
                w_state_nxt = ST_RX;
                if (bit_valid && !w_last) begin
                    w_shift_nxt = SHIFT_W'(bit_in);
                    w_count_nxt = CNT_W'(1);
                end else begin
                    w_shift_nxt = '0;
                    w_count_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_shift    <= '0;
            r_mode     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            mod_out    <= '0;
            frame_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_shift    <= w_shift_nxt;
            r_mode     <= w_mode_nxt;
            data_out   <= w_data_nxt;
            data_valid <= w_valid_nxt;
            mod_out    <= w_mod_out_nxt;
            frame_err  <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_dec_frame_deser.sv
// Bench for dec_frame_deser: directed frame scenarios plus random traffic,
// every cycle compared against a frame-level reference model.
module tb_dec_frame_deser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  work_mod = 2'b00;
    logic [31:0] data_out;
    logic        data_valid;
    logic [1:0]  mod_out;
    logic        frame_err;

    int n_total = 0;
    int n_bad   = 0;
    int n_valid = 0;
    int n_err   = 0;
    int cyc_no  = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;

    // reference model state
    bit          m_active = 0;
    int          m_len = 0;
    int          m_cnt = 0;
    logic [31:0] m_val = '0;
    logic [1:0]  m_mode = '0;
    logic [31:0] e_data = '0;
    logic [1:0]  e_mod = '0;
    logic        e_valid = 0;
    logic        e_err = 0;

    always #5 clk = ~clk;

    dec_frame_deser #(.MAX_CODEWORD_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .start      (start),
        .work_mod   (work_mod),
        .data_out   (data_out),
        .data_valid (data_valid),
        .mod_out    (mod_out),
        .frame_err  (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    function automatic int len_of(input logic [1:0] mode);
        case (mode)
            2'b00:   return 8;
            2'b01:   return 16;
            2'b10:   return 32;
            default: return 0;
        endcase
    endfunction

    function automatic void model_reset();
        m_active = 0; m_len = 0; m_cnt = 0; m_val = '0; m_mode = '0;
        e_data = '0; e_mod = '0; e_valid = 0; e_err = 0;
    endfunction

    // Frame-level behaviour: bits accumulate into an integer until the mode's length is reached.
    function automatic void model_step(input logic st, input logic [1:0] wm, input logic bv, input logic b);
        bit done;
        e_valid = 0;
        e_err   = 0;
        done    = 0;
        if (m_active && bv) begin
            m_val = (m_val << 1) | 32'(b);
            m_cnt++;
            if (m_cnt == m_len) begin
                done    = 1;
                e_data  = m_val;
                e_mod   = m_mode;
                e_valid = 1;
                m_active = 0;
            end
        end
        if (st) begin
            if (m_active) e_err = 1;
            if (len_of(wm) == 0) begin
                e_err = 1;
                m_active = 0;
            end else begin
                m_active = 1;
                m_mode = wm;
                m_len = len_of(wm);
                m_val = '0;
                m_cnt = 0;
                if (bv && !done) begin
                    m_val = 32'(b);
                    m_cnt = 1;
                end
            end
        end
    endfunction

    task automatic cyc(input logic st, input logic [1:0] wm, input logic bv, input logic b);
        start = st; work_mod = wm; bit_valid = bv; bit_in = b;
        @(posedge clk);
        cyc_no++;
        if (rst) model_reset();
        else model_step(st, wm, bv, b);
        #1;
        check("data_out", data_out, e_data);
        check("data_valid", 32'(data_valid), 32'(e_valid));
        check("mod_out", 32'(mod_out), 32'(e_mod));
        check("frame_err", 32'(frame_err), 32'(e_err));
        if (data_valid) begin
            n_valid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc_no;
        end
        if (frame_err) n_err++;
        start = 0; bit_valid = 0; bit_in = 0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input int maxgap);
        for (int i = n - 1; i >= 0; i--) begin
            int gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int g = 0; g < gap; g++) cyc(0, 2'(($urandom) & 3), 0, 1'($urandom));
            cyc(0, 2'b00, 1, w[i]);
        end
    endtask

    initial begin
        int v0, e0;
        logic [31:0] w;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data_out, 32'h0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_mod", 32'(mod_out), 0);
        check("rst_err", 32'(frame_err), 0);
        rst = 0;
        model_reset();

        // 1: mode 00, 0xB2
        v0 = n_valid; e0 = n_err;
        cyc(1, 2'b00, 0, 0);
        send_bits(32'hB2, 8, 0);
        check("t1_valid", 32'(data_valid), 1);
        check("t1_data", data_out, 32'h0000_00B2);
        check("t1_mod", 32'(mod_out), 0);
        cyc(0, 2'b00, 0, 0);
        check("t1_pulse", 32'(n_valid - v0), 1);

        // 2: mode 10, 0xDEADBEEF with gaps
        v0 = n_valid; e0 = n_err;
        cyc(1, 2'b10, 0, 0);
        send_bits(32'hDEAD_BEEF, 32, 5);
        cyc(0, 2'b00, 0, 0);
        check("t2_data", data_out, 32'hDEAD_BEEF);
        check("t2_mod", 32'(mod_out), 2);
        check("t2_pulses", 32'(n_valid - v0), 1);
        check("t2_errs", 32'(n_err - e0), 0);

        // 3: abort mode-01 frame after 7 bits
        v0 = n_valid; e0 = n_err;
        cyc(1, 2'b01, 0, 0);
        send_bits(32'h55, 7, 0);
        cyc(1, 2'b00, 0, 0);
        check("t3_err", 32'(frame_err), 1);
        check("t3_hold", data_out, 32'hDEAD_BEEF);
        send_bits(32'h5A, 8, 0);
        check("t3_data", data_out, 32'h0000_005A);
        check("t3_mod", 32'(mod_out), 0);
        check("t3_errs", 32'(n_err - e0), 1);

        // 4: illegal mode
        v0 = n_valid; e0 = n_err;
        cyc(1, 2'b11, 0, 0);
        check("t4_err", 32'(frame_err), 1);
        send_bits(32'hA5, 8, 0);
        cyc(0, 2'b00, 0, 0);
        check("t4_pulses", 32'(n_valid - v0), 0);
        check("t4_errs", 32'(n_err - e0), 1);
        check("t4_hold", data_out, 32'h0000_005A);

        // 5: back-to-back frames, second start on last bit
        v0 = n_valid; e0 = n_err;
        cyc(1, 2'b00, 0, 0);
        send_bits(32'h7F, 7, 0);
        cyc(1, 2'b00, 1, 1);
        check("t5_data0", data_out, 32'h0000_00FF);
        check("t5_err0", 32'(frame_err), 0);
        send_bits(32'h01, 8, 0);
        check("t5_data1", data_out, 32'h0000_0001);
        check("t5_gap", 32'(last_valid_cyc - prev_valid_cyc), 8);
        check("t5_pulses", 32'(n_valid - v0), 2);
        check("t5_errs", 32'(n_err - e0), 0);

        // 6: async reset mid-frame
        v0 = n_valid; e0 = n_err;
        cyc(1, 2'b01, 0, 0);
        send_bits(32'h3FF, 10, 0);
        #2 rst = 1;
        #1;
        check("t6_rst_data", data_out, 32'h0);
        check("t6_rst_valid", 32'(data_valid), 0);
        check("t6_rst_mod", 32'(mod_out), 0);
        check("t6_rst_err", 32'(frame_err), 0);
        model_reset();
        cyc(0, 2'b00, 1, 1);
        rst = 0;
        cyc(1, 2'b01, 0, 0);
        send_bits(32'h1234, 16, 0);
        check("t6_data", data_out, 32'h0000_1234);
        check("t6_mod", 32'(mod_out), 1);
        check("t6_pulses", 32'(n_valid - v0), 1);
        check("t6_errs", 32'(n_err - e0), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            cyc(($urandom_range(0, 19) == 0), 2'(w[1:0]), (w[4:2] != 3'b000), w[5]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
